// File: rtl/rs_block_packer_if.sv
// Byte-in / RS-symbol-out bundle between the UART RX path, the block packer and the encoder sink.
interface rs_block_packer_if #(
  parameter int unsigned M       = 8,
  parameter int unsigned FIFO_AW = 9
);
  logic [M-1:0]     in_data;
  logic             in_val;
  logic             source_ena;
  logic             source_val;
  logic             source_sop;
  logic             source_eop;
  logic [M-1:0]     rsin;
  logic [FIFO_AW:0] fifo_level;
  logic             overflow;

  // Packer side
  modport master (
    input  in_data, in_val, source_ena,
    output source_val, source_sop, source_eop, rsin, fifo_level, overflow
  );

  // Feeder / encoder side
  modport slave (
    output in_data, in_val, source_ena,
    input  source_val, source_sop, source_eop, rsin, fifo_level, overflow
  );
endinterface

// File: rtl/rs_block_packer.sv
// Buffers UART bytes in a FWFT FIFO and cuts them into fixed-length RS message blocks,
// padding short blocks after an idle timeout.
module rs_block_packer #(
  parameter int unsigned M         = 8,
  parameter int unsigned BLOCK_LEN = 247,
  parameter int unsigned FIFO_AW   = 9,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned PAD_SYM   = 0
) (
  input logic              clk,
  input logic              reset,
  rs_block_packer_if.master pkt_io
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned LVL_W  = FIFO_AW + 1;
  localparam int unsigned SYM_W  = $clog2(BLOCK_LEN);
  localparam int unsigned IDLE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [M-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [LVL_W-1:0]   data_left_q, data_left_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic               wr_en_c;
  logic               xfer_c;
  logic               pop_c;
  logic               sym_last_c;
  logic [M-1:0]       rsin_c;

  // A full FIFO drops the byte even when a pop happens in the same cycle
  assign wr_en_c    = pkt_io.in_val && (level_q < LVL_W'(DEPTH));
  assign xfer_c     = (state_q != S_IDLE) && pkt_io.source_ena;
  assign pop_c      = xfer_c && (state_q == S_DATA);
  assign sym_last_c = (sym_cnt_q == SYM_W'(BLOCK_LEN - 1));

  always_comb begin
    wr_ptr_d   = wr_ptr_q + FIFO_AW'(wr_en_c);
    rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop_c);
    level_d    = level_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    overflow_d = overflow_q | (pkt_io.in_val & ~wr_en_c);
  end

  // Storage carries no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= pkt_io.in_data;
    end
  end

  // Idle timer only runs while a partial block waits in IDLE; saturates at TIMEOUT
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q != S_IDLE) || pkt_io.in_val || (level_q == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q < IDLE_W'(TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    data_left_d = data_left_q;
    case (state_q)
      S_IDLE: begin
        if (level_q >= LVL_W'(BLOCK_LEN)) begin
          data_left_d = LVL_W'(BLOCK_LEN);
          state_d     = S_DATA;
        end else if ((level_q != '0) && (idle_cnt_q == IDLE_W'(TIMEOUT))) begin
          data_left_d = level_q;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          data_left_d = data_left_q - LVL_W'(1);
          sym_cnt_d   = sym_last_c ? '0 : sym_cnt_q + SYM_W'(1);
          if (data_left_q == LVL_W'(1)) begin
            state_d = sym_last_c ? S_IDLE : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (xfer_c) begin
          sym_cnt_d = sym_last_c ? '0 : sym_cnt_q + SYM_W'(1);
          if (sym_last_c) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      sym_cnt_q   <= '0;
      data_left_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      sym_cnt_q   <= sym_cnt_d;
      data_left_q <= data_left_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  // Stream outputs follow source_ena in the same cycle; all zero when nothing transfers
  always_comb begin
    rsin_c = '0;
    if (xfer_c) begin
      rsin_c = (state_q == S_DATA) ? mem_q[rd_ptr_q] : M'(PAD_SYM);
    end
  end

  assign pkt_io.source_val = xfer_c;
  assign pkt_io.source_sop = xfer_c && (sym_cnt_q == '0);
  assign pkt_io.source_eop = xfer_c && sym_last_c;
  assign pkt_io.rsin       = rsin_c;
  assign pkt_io.fifo_level = level_q;
  assign pkt_io.overflow   = overflow_q;

endmodule

// File: tb/tb_rs_block_packer.sv
// Randomized bench for rs_block_packer: observed symbol stream is compared against the
// accepted byte stream cut into 247-symbol blocks with zero padding.
module tb_rs_block_packer;

  localparam int unsigned BL    = 247;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned TMO   = 1024;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } sym_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rs_block_packer_if #(.M(8), .FIFO_AW(9)) bus ();

  rs_block_packer #(
    .M(8), .BLOCK_LEN(BL), .FIFO_AW(9), .TIMEOUT(TMO), .PAD_SYM(0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pkt_io (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         proto_err = 0;
  sym_t       obs_q[$];
  int         obs_cyc[$];
  logic [7:0] acc_q[$];
  sym_t       exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every transfer and note any stream-protocol violation
  always @(negedge clk) begin
    if (bus.source_val === 1'b1) begin
      obs_q.push_back({bus.rsin, bus.source_sop, bus.source_eop});
      obs_cyc.push_back(cyc);
      if (bus.source_ena !== 1'b1) proto_err++;
    end else if (bus.rsin !== 8'h00 || bus.source_sop !== 1'b0 || bus.source_eop !== 1'b0) begin
      proto_err++;
    end
  end

  // Reference: accepted bytes in order, zero-padded to whole blocks, sop/eop by position
  function automatic void build_exp();
    int n;
    exp_q.delete();
    n = acc_q.size();
    for (int i = 0; i < n; i++)
      exp_q.push_back({acc_q[i], (i % BL) == 0, (i % BL) == BL - 1});
    while ((exp_q.size() % BL) != 0) begin
      n = exp_q.size();
      exp_q.push_back({8'h00, (n % BL) == 0, (n % BL) == BL - 1});
    end
  endfunction

  task automatic put(input logic [7:0] d);
    @(posedge clk); #1;
    bus.in_data = d;
    bus.in_val  = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_val = 1'b0;
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic clear_scoreboard();
    obs_q.delete(); obs_cyc.delete(); acc_q.delete(); proto_err = 0;
  endtask

  task automatic test_reset();
    bus.in_val = 1'b0; bus.in_data = 8'h00; bus.source_ena = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.source_val !== 1'b0) begin miscompares++; $display("FAIL reset_val got %b exp 0", bus.source_val); end
    vectors++; if (bus.source_sop !== 1'b0) begin miscompares++; $display("FAIL reset_sop got %b exp 0", bus.source_sop); end
    vectors++; if (bus.source_eop !== 1'b0) begin miscompares++; $display("FAIL reset_eop got %b exp 0", bus.source_eop); end
    vectors++; if (bus.rsin !== 8'h00) begin miscompares++; $display("FAIL reset_rsin got %h exp 00", bus.rsin); end
    vectors++; if (bus.fifo_level !== 10'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_full_block();
    clear_scoreboard();
    bus.source_ena = 1'b1;
    for (int i = 0; i < BL; i++) begin put(8'(i)); acc_q.push_back(8'(i)); end
    idle(1);
    wait_obs(BL, 2000);
    idle(3);
    @(negedge clk);
    build_exp();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL full_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_sym[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    if (obs_cyc.size() == BL) begin
      vectors++; if (obs_cyc[BL-1] - obs_cyc[0] !== BL - 1) begin miscompares++; $display("FAIL full_contig got span %0d exp %0d", obs_cyc[BL-1] - obs_cyc[0], BL - 1); end
    end
    vectors++; if (bus.fifo_level !== 10'd0) begin miscompares++; $display("FAIL full_level got %0d exp 0", bus.fifo_level); end
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL full_proto got %0d exp 0", proto_err); end
  endtask

  task automatic test_timeout();
    int t_wr;
    int lat;
    int sops;
    clear_scoreboard();
    bus.source_ena = 1'b1;
    for (int i = 0; i < 5; i++) begin put(8'hA1 + 8'(i)); acc_q.push_back(8'hA1 + 8'(i)); end
    t_wr = cyc;
    idle(1);
    wait_obs(BL, TMO + 600);
    idle(2);
    build_exp();
    lat = (obs_cyc.size() > 0) ? obs_cyc[0] - t_wr : -1;
    vectors++; if (lat < TMO + 1 || lat > TMO + 3) begin miscompares++; $display("FAIL timeout_latency got %0d exp %0d..%0d", lat, TMO + 1, TMO + 3); end
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL timeout_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    sops = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i].sop) sops++;
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL timeout_sym[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    vectors++; if (sops !== 1) begin miscompares++; $display("FAIL timeout_blocks got %0d exp 1", sops); end
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL timeout_proto got %0d exp 0", proto_err); end
  endtask

  task automatic test_backpressure();
    int sops;
    int eops;
    int seed_dummy;
    clear_scoreboard();
    seed_dummy = $urandom(1);
    for (int c = 0; c < 5000 && (c < BL || obs_q.size() < BL); c++) begin
      @(posedge clk); #1;
      bus.in_val = (c < BL);
      if (c < BL) begin
        bus.in_data = 8'($urandom);
        acc_q.push_back(bus.in_data);
      end
      bus.source_ena = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.in_val = 1'b0; bus.source_ena = 1'b1;
    idle(2);
    build_exp();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    sops = 0; eops = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i].sop) sops++;
      if (obs_q[i].eop) eops++;
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bp_sym[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    vectors++; if (sops !== 1 || eops !== 1) begin miscompares++; $display("FAIL bp_sop_eop got %0d/%0d exp 1/1", sops, eops); end
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL bp_proto got %0d exp 0", proto_err); end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_scoreboard();
    bus.source_ena = 1'b1;
    for (int i = 0; i < 2 * BL; i++) begin
      put(8'($urandom));
      acc_q.push_back(bus.in_data);
    end
    idle(1);
    wait_obs(2 * BL, 3000);
    idle(2);
    build_exp();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_sym[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    gap = (obs_cyc.size() > BL) ? obs_cyc[BL] - obs_cyc[BL-1] : -1;
    vectors++; if (gap !== 2) begin miscompares++; $display("FAIL b2b_gap got %0d exp 2", gap); end
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL b2b_proto got %0d exp 0", proto_err); end
  endtask

  task automatic test_overflow();
    clear_scoreboard();
    bus.source_ena = 1'b0;
    for (int i = 0; i < 520; i++) begin
      put(8'(i * 7 + 3));
      if (i < DEPTH) acc_q.push_back(8'(i * 7 + 3));
      if (i == DEPTH) begin
        @(negedge clk);
        vectors++; if (bus.fifo_level !== 10'(DEPTH)) begin miscompares++; $display("FAIL ovf_level_at513 got %0d exp %0d", bus.fifo_level, DEPTH); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b exp 0", bus.overflow); end
      end
    end
    idle(1);
    @(negedge clk);
    vectors++; if (bus.fifo_level !== 10'(DEPTH)) begin miscompares++; $display("FAIL ovf_level got %0d exp %0d", bus.fifo_level, DEPTH); end
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    vectors++; if (obs_q.size() !== 0) begin miscompares++; $display("FAIL ovf_held got %0d exp 0", obs_q.size()); end
    @(posedge clk); #1;
    bus.source_ena = 1'b1;
    wait_obs(3 * BL, 4000);
    idle(2);
    build_exp();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL ovf_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ovf_sym[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL ovf_proto got %0d exp 0", proto_err); end
  endtask

  task automatic test_reset_mid_block();
    clear_scoreboard();
    bus.source_ena = 1'b1;
    for (int i = 0; i < BL; i++) put(8'($urandom));
    idle(1);
    wait_obs(100, 2000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.source_val !== 1'b0) begin miscompares++; $display("FAIL mid_val got %b exp 0", bus.source_val); end
    vectors++; if (bus.source_sop !== 1'b0 || bus.source_eop !== 1'b0) begin miscompares++; $display("FAIL mid_sop_eop got %b/%b exp 0/0", bus.source_sop, bus.source_eop); end
    vectors++; if (bus.rsin !== 8'h00) begin miscompares++; $display("FAIL mid_rsin got %h exp 00", bus.rsin); end
    vectors++; if (bus.fifo_level !== 10'd0) begin miscompares++; $display("FAIL mid_level got %0d exp 0", bus.fifo_level); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL mid_overflow got %b exp 0", bus.overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    clear_scoreboard();
    for (int i = 0; i < BL; i++) begin
      put(8'($urandom));
      acc_q.push_back(bus.in_data);
    end
    idle(1);
    wait_obs(BL, 2000);
    idle(3);
    build_exp();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL mid_fresh_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mid_fresh_sym[%0d] got %h/%b/%b exp %h/%b/%b", i, obs_q[i].d, obs_q[i].sop, obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
      end
    end
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL mid_proto got %0d exp 0", proto_err); end
  endtask

  initial begin
    bus.in_val = 1'b0; bus.in_data = 8'h00; bus.source_ena = 1'b1;
    test_reset();
    test_full_block();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_block_packer.md
Name: rs_block_packer

Overview:
- Upstream feeder for the RS encoder lane (m=8, 8 check symbols).
- Buffers the byte stream from the UART receive path in a FIFO.
- Cuts the buffered stream into fixed-length RS message blocks and presents them on the encoder's ena/val/sop/eop streaming sink.
- Pads partial blocks after an idle timeout so that short messages still get encoded and transmitted.

Parameters:
- M, 8: symbol width in bits; matches encoder m.
- BLOCK_LEN, 247: data symbols per RS block (n=255 minus 8 check symbols).
- FIFO_AW, 9: FIFO address width; depth is 2^FIFO_AW = 512.
- TIMEOUT, 1024: idle cycles before a partial block is flushed with padding; legal range 1 to 65535.
- PAD_SYM, 0: symbol value used for padding.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- in_data  in  M: byte from UART RX.
- in_val  in  1: in_data valid this cycle. Single-cycle strobe; the source cannot be back-pressured.
- source_ena  in  1: encoder sink_ena; the encoder can accept a symbol this cycle.
- source_val  out  1: symbol valid to encoder (drives encoder sink_val).
- source_sop  out  1: first symbol of block.
- source_eop  out  1: last symbol of block.
- rsin  out  M: symbol to encoder.
- fifo_level  out  FIFO_AW+1: current FIFO occupancy.
- overflow  out  1: sticky; set when an input byte was dropped.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: source_val, source_sop and source_eop are 0; rsin is 0; fifo_level is 0; overflow is 0. FSM goes to IDLE and all counters clear.
- Reset mid-block: the block is abandoned with no eop issued, and FIFO contents are discarded.
- FIFO:
  - First-word-fall-through, with pointers that wrap modulo 2^FIFO_AW.
  - Write occurs on in_val when fifo_level < 2^FIFO_AW. When full, the byte is dropped and overflow is set; overflow clears only on reset.
  - A full FIFO drops the byte even if a read happens in the same cycle.
  - Simultaneous write and read leaves fifo_level unchanged.
  - fifo_level is registered and reflects writes and reads from the previous cycle.
- Transfer rule:
  - A symbol transfers in any cycle with source_val=1.
  - source_val is combinational: state is DATA or PAD, AND source_ena=1.
  - source_val is never asserted while source_ena=0.
  - rsin, source_sop and source_eop are 0 whenever source_val=0.
- Counters:
  - sym_cnt runs 0..BLOCK_LEN-1 and increments on each transfer.
  - source_sop = (sym_cnt==0) qualified by source_val.
  - source_eop = (sym_cnt==BLOCK_LEN-1) qualified by source_val.
  - data_left is a snapshot of the symbols that will come from the FIFO in this block.
  - idle_cnt counts consecutive cycles with in_val=0 while in IDLE with fifo_level>0. It clears on in_val, and it clears when fifo_level==0.
- FSM states and transitions:
  - IDLE:
    - If fifo_level >= BLOCK_LEN: set data_left=BLOCK_LEN, go to DATA.
    - Else if fifo_level>0 and idle_cnt reaches TIMEOUT: set data_left=fifo_level, go to DATA.
    - Otherwise stay. The full-block condition has priority over timeout.
  - DATA:
    - rsin = FIFO head. Each transfer pops the FIFO and decrements data_left.
    - On the transfer where data_left goes 1 to 0: if sym_cnt==BLOCK_LEN-1, go to IDLE; else go to PAD.
    - The FIFO is never empty in DATA, because of the snapshot.
  - PAD:
    - rsin = PAD_SYM with no FIFO pop.
    - On the eop transfer, go to IDLE.
    - Bytes arriving during PAD stay queued for the next block.
- Latency: the first symbol can transfer in the cycle after the FSM leaves IDLE (entry decision is registered). The minimum gap between blocks is 1 idle cycle.
- Arithmetic: no wrap on idle_cnt; it saturates at TIMEOUT.

Test Plan:
- Full block, ena held high: write 247 bytes 0x00..0xF6 back-to-back → one block of 247 consecutive source_val cycles. sop on 0x00, eop on 0xF6, fifo_level returns to 0.
- Timeout flush: write 5 bytes 0xA1..0xA5, then idle → after 1024 idle cycles a block starts: 5 data symbols, then 242 symbols of 0x00. eop on the 247th symbol; total block count 1.
- Backpressure: during a full block, toggle source_ena at random (seed 1) → source_val is never high with ena low, no symbol is lost or duplicated, order is preserved, and exactly one sop and one eop occur.
- Overflow: hold ena low and write 520 bytes → fifo_level=512 and overflow=1 after byte 513. Releasing ena emits 512 bytes in order, with bytes 513-520 absent.
- Continuous stream: write 494 bytes at one per cycle with ena high → two back-to-back blocks. The second sop follows the first eop after at most 1 idle cycle.
- Reset mid-block: assert reset at symbol 100 of a block → next cycle all outputs are 0 and fifo_level=0. A fresh 247-byte write then produces a clean block starting with sop.
